// File: rtl/mips_selftest_pkg.sv
// Shared types for the MIPS self-test sequencer: FSM states, test-index width,
// and the expected signature-store pair.
package mips_selftest_pkg;
  localparam int TIDX_W = 4;

  typedef enum logic [1:0] {S_RST, S_RUN, S_EVAL, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } exp_pair_t;
endpackage

// File: rtl/mips_selftest_expect.sv
// Signature ROM: maps a test-program index to the (address, data) store that
// marks that program as having run to completion correctly.
module mips_selftest_expect
  import mips_selftest_pkg::*;
(
  input  logic [TIDX_W-1:0] idx,
  output exp_pair_t         pair
);
  always_comb begin
    pair = '0;
    case (idx)
      4'd0:  pair = '{adr: 32'h0000_0014, data: 32'h0000_0015};
      4'd1:  pair = '{adr: 32'h0000_0054, data: 32'h0000_0007};
      4'd2:  pair = '{adr: 32'h70f0_0ff0, data: 32'h0000_0002};
      4'd3:  pair = '{adr: 32'h8f0f_f010, data: 32'h0000_0002};
      4'd4:  pair = '{adr: 32'h0fff_fffc, data: 32'h0000_03f8};
      4'd5:  pair = '{adr: 32'h0000_002c, data: 32'h0000_0009};
      4'd6:  pair = '{adr: 32'h1263_ff00, data: 32'h0000_0000};
      4'd7:  pair = '{adr: 32'h0000_0014, data: 32'h5500_00ff};
      4'd8:  pair = '{adr: 32'h0000_0018, data: 32'h0000_001f};
      4'd9:  pair = '{adr: 32'h0000_000c, data: 32'h0000_000c};
      4'd10: pair = '{adr: 32'h0000_0000, data: 32'h0000_0004};
      4'd11: pair = '{adr: 32'h0000_0000, data: 32'h0000_0004};
      4'd12: pair = '{adr: 32'h0000_0000, data: 32'h0000_0dac};
      default: pair = '0;
    endcase
  end
endmodule

// File: rtl/mips_selftest_seq.sv
// On-chip regression sequencer: resets the core once per test program, watches
// its store bus for the program's signature, and tallies pass/fail per test.
module mips_selftest_seq
  import mips_selftest_pkg::*;
#(
  parameter int NUM_TESTS    = 13,
  parameter int RESET_CYCLES = 2,
  parameter int TEST_CYCLES  = 98,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memwrite,
  input  logic [31:0]          dataadr,
  input  logic [31:0]          writedata,
  output logic                 cpu_reset,
  output logic [TIDX_W-1:0]    test_sel,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           pass_count,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [CNT_W-1:0]     stray_writes
);
  localparam int CYC_MAX = (RESET_CYCLES > TEST_CYCLES) ? RESET_CYCLES : TEST_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0]  RST_LAST  = CYC_W'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0]  RUN_LAST  = CYC_W'(TEST_CYCLES - 1);
  localparam logic [TIDX_W-1:0] LAST_TEST = TIDX_W'(NUM_TESTS - 1);

  state_t           state;
  logic [CYC_W-1:0] cyc;
  logic             hit;
  exp_pair_t        exp_pair;
  logic             wr_match;

  mips_selftest_expect u_expect (
    .idx  (test_sel),
    .pair (exp_pair)
  );

  // Unknown bus values evaluate false here, so they can never register a hit.
  assign wr_match = (dataadr == exp_pair.adr) && (writedata == exp_pair.data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_RST;
      cyc          <= '0;
      hit          <= 1'b0;
      cpu_reset    <= 1'b1;
      test_sel     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass_count   <= '0;
      fail_mask    <= '0;
      stray_writes <= '0;
    end else begin
      case (state)
        S_RST: begin
          busy      <= 1'b1;
          cpu_reset <= 1'b1;
          hit       <= 1'b0;
          if (cyc == RST_LAST) begin
            state     <= S_RUN;
            cyc       <= '0;
            cpu_reset <= 1'b0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_RUN: begin
          if (memwrite) begin
            if (wr_match)
              hit <= 1'b1;
            else if (stray_writes != '1)
              stray_writes <= stray_writes + 1'b1;
          end
          // A hit on the final window cycle lands in hit before EVAL reads it.
          if (cyc == RUN_LAST) begin
            state     <= S_EVAL;
            cyc       <= '0;
            cpu_reset <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_EVAL: begin
          if (hit)
            pass_count <= pass_count + 5'd1;
          else
            fail_mask <= fail_mask | (NUM_TESTS'(1) << test_sel);
          hit <= 1'b0;
          if (test_sel == LAST_TEST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            test_sel <= test_sel + 1'b1;
            state    <= S_RST;
          end
        end
        S_DONE: begin
        end
        default: state <= S_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_selftest_seq.sv
// Bench for mips_selftest_seq: a bus model replaces the core, final results are
// scoreboarded, and phase/handshake outputs are checked every cycle.
module tb_mips_selftest_seq;
  localparam int NT     = 13;
  localparam int PER    = 101;
  localparam int SAT_TC = 5100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, memwrite;
  logic [31:0] dataadr, writedata;
  logic        cpu_reset, busy, done;
  logic [3:0]  test_sel;
  logic [4:0]  pass_count;
  logic [12:0] fail_mask;
  logic [15:0] stray_writes;

  logic        reset_s, memwrite_s;
  logic [31:0] dataadr_s, writedata_s;
  logic        cpu_reset_s, busy_s, done_s;
  logic [3:0]  test_sel_s;
  logic [4:0]  pass_count_s;
  logic [12:0] fail_mask_s;
  logic [15:0] stray_writes_s;

  mips_selftest_seq #(.NUM_TESTS(NT)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cpu_reset(cpu_reset), .test_sel(test_sel),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_mask(fail_mask),
    .stray_writes(stray_writes)
  );

  // Long run windows so the stray counter can be pushed past 0xffff.
  mips_selftest_seq #(.NUM_TESTS(NT), .TEST_CYCLES(SAT_TC)) dut_sat (
    .clk(clk), .reset(reset_s), .memwrite(memwrite_s), .dataadr(dataadr_s),
    .writedata(writedata_s), .cpu_reset(cpu_reset_s), .test_sel(test_sel_s),
    .busy(busy_s), .done(done_s), .pass_count(pass_count_s), .fail_mask(fail_mask_s),
    .stray_writes(stray_writes_s)
  );

  typedef struct packed {
    logic [4:0]  pass;
    logic [12:0] mask;
    logic [15:0] stray;
  } res_t;

  res_t        sb[$];
  logic [31:0] ea[NT];
  logic [31:0] ed[NT];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic stim(input int sc, input int t, input int p,
                      output logic mw, output logic [31:0] a, output logic [31:0] d);
    mw = 1'b0; a = '0; d = '0;
    case (sc)
      1: if (p == 12) begin mw = 1'b1; a = 32'h14; d = 32'h15; end
      2: if (p == 99) begin mw = 1'b1; a = ea[t]; d = ed[t]; end
      3: begin
        if (t == 0 && p == 100) begin mw = 1'b1; a = 32'h54; d = 32'h7; end
        if (t == 1 && p == 0)   begin mw = 1'b1; a = 32'h54; d = 32'h7; end
        if (t == 1 && p == 1)   begin mw = 1'b1; a = 32'h54; d = 32'h8; end
        if (t == 2 && p == 1)   begin mw = 1'b1; a = 32'h70f00ff0; d = 32'h2; end
        if (t == 1 && p == 20)  begin mw = 1'b1; a = 32'h54; d = 32'h8; end
        if (t == 1 && p == 30)  begin mw = 1'b1; a = 32'h54; d = 32'h7; end
      end
      default: ;
    endcase
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_test_sel"}, 32'(test_sel), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass_count), 32'd0);
    chk({tag, "_mask"}, 32'(fail_mask), 32'd0);
    chk({tag, "_stray"}, 32'(stray_writes), 32'd0);
  endtask

  task automatic run_seq(input int sc, input int abort_g);
    res_t        e;
    logic        mw;
    logic [31:0] a, d;
    int          t, p, tm, ev;
    bit          seen;
    bit          exp_cr;
    if (abort_g < 0) begin
      case (sc)
        1: begin e.pass = 5'd1;  e.mask = 13'h1ffe; e.stray = 16'd12; end
        2: begin e.pass = 5'd13; e.mask = 13'h0000; e.stray = 16'd0;  end
        default: begin e.pass = 5'd1; e.mask = 13'h1ffd; e.stray = 16'd1; end
      endcase
      sb.push_back(e);
    end
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    seen = 1'b0;
    for (int g = 0; g <= NT * PER + 5 && !seen; g++) begin
      t  = g / PER;
      p  = g % PER;
      tm = (t > NT - 1) ? NT - 1 : t;
      ev = (t > NT) ? NT : t;
      exp_cr = (g < NT * PER) ? !(p >= 2 && p <= 99) : 1'b1;
      chk("cpu_reset", 32'(cpu_reset), 32'(exp_cr));
      chk("test_sel", 32'(test_sel), 32'(tm));
      chk("busy", 32'(busy), 32'(g >= 1 && g < NT * PER));
      chk("done", 32'(done), 32'(g >= NT * PER));
      chk("tally", 32'(int'(pass_count) + $countones(fail_mask)), 32'(ev));
      if (done && sb.size() > 0) begin
        e = sb.pop_front();
        chk("final_pass", 32'(pass_count), 32'(e.pass));
        chk("final_mask", 32'(fail_mask), 32'(e.mask));
        chk("final_stray", 32'(stray_writes), 32'(e.stray));
        seen = 1'b1;
      end
      if (g == abort_g) begin
        chk("pre_abort_pass", 32'(pass_count), 32'd5);
        reset = 1'b1;
        #1;
        chk_reset_vals("abort");
        return;
      end
      if (g < NT * PER) stim(sc, tm, p, mw, a, d);
      else begin mw = 1'b0; a = '0; d = '0; end
      memwrite = mw; dataadr = a; writedata = d;
      @(posedge clk);
      #1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset_s = 1'b1; memwrite_s = 1'b1; dataadr_s = 32'hdead_beef; writedata_s = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_s = 1'b0;
  end

  initial begin
    ea[0]  = 32'h14;       ed[0]  = 32'h15;
    ea[1]  = 32'h54;       ed[1]  = 32'h7;
    ea[2]  = 32'h70f00ff0; ed[2]  = 32'h2;
    ea[3]  = 32'h8f0ff010; ed[3]  = 32'h2;
    ea[4]  = 32'h0ffffffc; ed[4]  = 32'h3f8;
    ea[5]  = 32'h2c;       ed[5]  = 32'h9;
    ea[6]  = 32'h1263ff00; ed[6]  = 32'h0;
    ea[7]  = 32'h14;       ed[7]  = 32'h550000ff;
    ea[8]  = 32'h18;       ed[8]  = 32'h1f;
    ea[9]  = 32'hc;        ed[9]  = 32'hc;
    ea[10] = 32'h0;        ed[10] = 32'h4;
    ea[11] = 32'h0;        ed[11] = 32'h4;
    ea[12] = 32'h0;        ed[12] = 32'hdac;

    run_seq(1, -1);
    run_seq(2, -1);
    run_seq(3, -1);
    run_seq(2, 5 * PER + 50);
    run_seq(1, -1);

    for (int i = 0; i < 70000 && !done_s; i++) @(posedge clk);
    #1;
    chk("sat_done", 32'(done_s), 32'd1);
    chk("sat_stray", 32'(stray_writes_s), 32'h0000ffff);
    chk("sat_pass", 32'(pass_count_s), 32'd0);
    chk("sat_mask", 32'(fail_mask_s), 32'h1fff);
    chk("sat_busy", 32'(busy_s), 32'd0);
    chk("sat_cpu_reset", 32'(cpu_reset_s), 32'd1);
    chk("sat_test_sel", 32'(test_sel_s), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
